// File: rtl/xbutton_event_queue.sv
// xbutton_event_queue: three debounced push-buttons feeding a small press-event FIFO
// behind a register bus (EVENT pop, STATUS, CTRL flush/overflow-clear).
module xbutton_event_queue #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DEPTH           = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  bt,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);
   localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [2:0]      s1_q, s2_q, stable_q, stable_d, pend_q, pend_d, push_oh;
   logic [CW-1:0]   cnt_q [3];
   logic [CW-1:0]   cnt_d [3];
   logic [1:0]      mem_q [DEPTH];
   logic [1:0]      mem_d [DEPTH];
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            push, pop, flush, clr_ovf, full, wr;
   logic [1:0]      code;
   logic            unused_bits;

   assign unused_bits = &{1'b0, data_in[31:2]};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
               stable_d[i] = s2_q[i];
            else
               cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Lowest-index pending button is pushed; new presses join the pending set.
   always_comb begin
      push    = |pend_q;
      push_oh = pend_q & (~pend_q + 3'd1);
      code    = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : 2'd2;
      pend_d  = (pend_q & ~push_oh) | (stable_d & ~stable_q);
   end

   always_comb begin
      full    = count_q == CNTW'(DEPTH);
      pop     = sel & ~we & (addr == 2'd0) & (count_q != '0);
      flush   = sel & we & (addr == 2'd2) & data_in[0];
      clr_ovf = sel & we & (addr == 2'd2) & data_in[1];
      wr      = push & (~full | pop) & ~flush;
      mem_d   = mem_q;
      if (wr)
         mem_d[wp_q] = code;
      wp_d    = flush ? '0 : wp_q + AW'(wr);
      rp_d    = flush ? '0 : rp_q + AW'(pop);
      count_d = flush ? '0 : count_q + CNTW'(wr) - CNTW'(pop);
      ovf_d   = (ovf_q & ~clr_ovf) | (push & full & ~pop & ~flush);
   end

   always_comb begin
      data_out = '0;
      if (sel & ~we)
         data_out = (addr == 2'd0) ? ((count_q != '0) ? {23'd0, 1'b1, 6'd0, mem_q[rp_q]} : '0) :
                    (addr == 2'd1) ? {21'd0, stable_q, 3'd0, ovf_q, 1'b0, 3'(count_q)} : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         cnt_q    <= '{default: '0};
         pend_q   <= '0;
         mem_q    <= '{default: '0};
         wp_q     <= '0;
         rp_q     <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         s1_q     <= bt;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         mem_q    <= mem_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule

// File: tb/tb_xbutton_event_queue.sv
// tb_xbutton_event_queue: scoreboard bench with a run-length debounce model and queue-based FIFO model.
module tb_xbutton_event_queue;
   localparam int D   = 4;
   localparam int DEP = 4;

   logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, we = 1'b0;
   logic [2:0]  bt = '0;
   logic [1:0]  addr = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;

   logic [31:0] exp_q[$];
   int          n_vec = 0, n_err = 0;

   bit [2:0] m_stab, m_pend, p1, p2;
   bit       m_ovf;
   int       m_run[3];
   int       fq[$];

   xbutton_event_queue #(.DEBOUNCE_CYCLES(D), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst), .bt(bt), .sel(sel), .we(we),
      .addr(addr), .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, %0d reads still expected", exp_q.size());
      $fatal(1);
   end

   initial forever begin
      logic [31:0] e;
      @(negedge clk);
      #1;
      if (sel && !we) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL read addr=%0d: no expected value queued, got %h", addr, data_out);
         end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
               n_err++;
               $display("FAIL read addr=%0d: got %h, expected %h", addr, data_out, e);
            end
         end
      end
   end

   function automatic logic [31:0] mread(input logic [1:0] a);
      if (a == 2'd0) return (fq.size() > 0) ? (32'h100 | 32'(fq[0])) : 32'd0;
      if (a == 2'd1) return (32'(m_stab) << 8) | (32'(m_ovf) << 4) | 32'(fq.size());
      return 32'd0;
   endfunction

   function automatic void mclear();
      m_stab = '0; m_pend = '0; p1 = '0; p2 = '0; m_ovf = 0;
      m_run = '{0, 0, 0};
      fq.delete();
   endfunction

   // One clock edge of the reference: the level seen by the debouncer is bt from two edges back.
   function automatic void medge();
      bit [2:0] lvl;
      int       k;
      lvl = p2; p2 = p1; p1 = bt;
      k = -1;
      for (int i = 0; i < 3; i++)
         if (k < 0 && m_pend[i]) begin k = i; m_pend[i] = 0; end
      for (int i = 0; i < 3; i++) begin
         if (lvl[i] != m_stab[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_stab[i] = lvl[i];
               m_run[i] = 0;
               if (lvl[i]) m_pend[i] = 1;
            end
         end else m_run[i] = 0;
      end
      if (sel && we && addr == 2'd2 && data_in[1]) m_ovf = 0;
      if (sel && we && addr == 2'd2 && data_in[0]) fq.delete();
      else begin
         if (sel && !we && addr == 2'd0 && fq.size() > 0) void'(fq.pop_front());
         if (k >= 0) begin
            if (fq.size() < DEP) fq.push_back(k);
            else m_ovf = 1;
         end
      end
   endfunction

   task automatic step(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input longint want);
      sel = s; we = w; addr = a; data_in = d;
      if (s && !w) exp_q.push_back(want >= 0 ? 32'(want) : mread(a));
      @(posedge clk);
      if (rst) medge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 2'd0, 32'd0, -1);
   endtask

   task automatic rd(input logic [1:0] a, input longint want);
      step(1, 0, a, 32'd0, want);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      step(1, 1, a, d, -1);
   endtask

   task automatic press(input int b);
      bt = 3'(1 << b); idle(8);
      bt = '0;         idle(8);
   endtask

   initial begin
      int hold, r;
      mclear();
      @(negedge clk);
      rd(1, 0); rd(0, 0);
      rst = 1'b1;
      rd(1, 0); rd(0, 0);

      bt = 3'b001; idle(6);
      rd(0, 0); rd(1, 'h101); rd(0, 'h100); rd(0, 0);
      bt = '0; idle(10); rd(1, 0);

      for (int i = 0; i < 10; i++) begin
         bt = (i % 2) ? 3'b000 : 3'b010;
         idle(2);
      end
      bt = '0; idle(10); rd(1, 0); rd(0, 0);

      bt = 3'b111; idle(6);
      rd(1, 'h700); rd(1, 'h701); rd(1, 'h702); rd(1, 'h703);
      rd(0, 'h100); rd(0, 'h101); rd(0, 'h102); rd(0, 0);
      bt = '0; idle(10);

      repeat (5) press(2);
      rd(1, 'h014); wr(2, 32'h2); rd(1, 'h004); wr(2, 32'h1); rd(1, 0);

      press(0); press(1); press(2); press(0);
      rd(1, 'h004);
      bt = 3'b010; idle(6);
      rd(0, 'h100); rd(1, 'h204);
      bt = '0; idle(8);
      rd(0, 'h101); rd(0, 'h102); rd(0, 'h100); rd(0, 'h101); rd(0, 0); rd(1, 0);

      bt = 3'b011; idle(8); bt = '0; idle(8);
      rd(1, 'h002);
      bt = 3'b100; idle(5);
      #2 rst = 1'b0;
      mclear();
      @(negedge clk);
      rd(1, 0); rd(0, 0);
      rst = 1'b1;
      rd(1, 0); idle(5);
      rd(1, 'h400); rd(1, 'h401); rd(0, 'h102); rd(0, 0);
      bt = '0; idle(10); rd(1, 0);

      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            bt = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 14);
         end
         hold--;
         r = $urandom_range(0, 99);
         if (r < 20)      rd(0, -1);
         else if (r < 35) rd(1, -1);
         else if (r < 40) rd(2'($urandom_range(2, 3)), -1);
         else if (r < 44) wr(2, 32'($urandom_range(0, 3)));
         else if (r < 46) wr(3, $urandom);
         else             idle(1);
      end
      bt = '0; idle(3);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected reads never observed, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/xbutton_event_queue.md
XBUTTON_EVENT_QUEUE -- requirements
Module: xbutton_event_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive cycles a synchronised level must differ from the stable level before the stable level changes.
REQ-002 SHALL have parameter DEPTH, default 4: event FIFO entries (power of two).
REQ-003 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bt, input, 3: raw asynchronous push-button levels, 1 = pressed.
REQ-006 SHALL have port sel, input, 1: bus select from the address decoder.
REQ-007 SHALL have port we, input, 1: bus write enable; read when sel=1 and we=0.
REQ-008 SHALL have port addr, input, 2: register offset.
REQ-009 SHALL have port data_in, input, 32: bus write data.
REQ-010 SHALL have port data_out, output, 32: combinational read data, 0 when sel=0.

Function
REQ-011 SHALL pass each bt bit through a 2-flop synchroniser before any other use.
REQ-012 SHALL keep one stable level and one counter per button; the counter increments while the synchronised level differs from the stable level and clears to 0 when they match.
REQ-013 SHALL load the stable level with the synchronised level, and clear the counter, in the cycle the counter reaches DEBOUNCE_CYCLES-1 with mismatch still present.
REQ-014 SHALL raise a per-button pending flag on each stable 0->1 transition; releases generate no event.
REQ-015 SHALL push at most one event per cycle: the lowest-index pending button, code = index (0..2); its pending flag clears in the same cycle.
REQ-016 SHALL keep the other pending flags set until pushed in later cycles, preserving no order other than index priority.
REQ-017 SHALL decode offsets: 0 = EVENT (read-pop), 1 = STATUS (read), 2 = CTRL (write), 3 = reads 0, writes ignored.
REQ-018 SHALL return on EVENT read: bit 8 = valid (FIFO non-empty), bits 1:0 = head code, all other bits 0; entire word 0 when empty.
REQ-019 SHALL pop the head on the clock edge ending a cycle with sel=1, we=0, addr=0, FIFO non-empty; the same read on an empty FIFO changes nothing.
REQ-020 SHALL return on STATUS read: bits 2:0 = count (0..DEPTH), bit 4 = overflow sticky, bits 10:8 = stable levels of buttons 2..0, others 0.
REQ-021 SHALL, on CTRL write, flush the FIFO (count 0, pointers 0) if data_in[0]=1 and clear overflow if data_in[1]=1; pending flags are not affected.
REQ-022 SHALL, on a push while full with no simultaneous pop, drop the event, clear its pending flag, and set overflow.
REQ-023 SHALL, on simultaneous push and pop, perform both (count unchanged), including when full (no overflow).
REQ-024 SHALL give flush priority over a simultaneous push: the FIFO ends empty and the pushed event is discarded without setting overflow.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL ensure a clean press reaches the FIFO head exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the bt edge is sampled.

Reset
REQ-027 SHALL, while rst=0, immediately clear synchronisers, stable levels, counters, pending flags, FIFO pointers, count and overflow, independent of clk.
REQ-028 SHALL produce data_out = 0 during reset and discard any in-flight debounce or pending event; after release, buttons already held produce no event until released and pressed again... except that a held button becomes stable-1 after debounce and therefore SHALL generate one event.

Verification (DEBOUNCE_CYCLES=4, DEPTH=4)
REQ-029 SHALL test a clean press: bt=001 held -> EVENT read returns 0x100 (valid, code 0) from cycle 7 after the edge; STATUS count=1; a second EVENT read returns 0.
REQ-030 SHALL test bounce: bt[1] toggled every 2 cycles for 20 cycles then held 0 -> no event, STATUS count=0, stable bit 9 = 0.
REQ-031 SHALL test simultaneous press: bt 000->111 -> events pushed on 3 consecutive cycles, EVENT reads return 0x100, 0x101, 0x102 in order.
REQ-032 SHALL test overflow: 5 presses of button 2 without reads -> count=4, bit 4 set; CTRL write 0x2 clears bit 4; CTRL write 0x1 -> count=0.
REQ-033 SHALL test full push+pop: FIFO full, EVENT read in the cycle a new event pushes -> count stays 4, overflow stays 0, new code at tail.
REQ-034 SHALL test reset mid-operation: rst=0 asynchronously with count=2 and a counter at 3 -> STATUS reads 0 after release; button held through reset yields exactly one event.
